// File: rtl/fib_param_amisha.sv
`default_nettype none
// ============================================================================
//  Module      : fib_param_amisha
//  Description : Iterative Fibonacci / Lucas sequence generator (FSMD) with
//                parametrised index/result widths, sticky overflow tracking
//                with saturation, and a synchronous abort. Operates behind a
//                start / ready / done_tick handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module fib_param_amisha #(
    parameter int IW = 5,   // index width
    parameter int DW = 20   // result width (>= 2 so the Lucas seed 2 fits)
) (
    input  logic          clk_amisha,
    input  logic          reset_amisha,
    input  logic          start_amisha,
    input  logic          mode_amisha,
    input  logic          abort_amisha,
    input  logic [IW-1:0] i_amisha,
    output logic          ready_amisha,
    output logic          done_tick_amisha,
    output logic          ovf_amisha,
    output logic [DW-1:0] f_amisha
);

    // State encoding
    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_OP   = 2'd1;
    localparam logic [1:0] c_S_DONE = 2'd2;

    // Sequence seeds: Fibonacci starts 0,1; Lucas starts 2,1
    localparam logic [DW-1:0] c_SEED_A_FIB   = '0;
    localparam logic [DW-1:0] c_SEED_A_LUCAS = DW'(2);
    localparam logic [DW-1:0] c_SEED_B       = DW'(1);
    localparam logic [DW-1:0] c_ALL_ONES     = '1;

    logic [1:0]    r_state;
    logic [1:0]    w_state_next;

    logic [DW-1:0] r_a;
    logic [DW-1:0] r_b;
    logic          r_a_ovf;
    logic          r_b_ovf;
    logic [IW-1:0] r_n;
    logic [DW-1:0] r_f;
    logic          r_ovf;

    // One extra bit so the carry out of a+b is visible
    logic [DW:0]   w_sum;
    logic          w_step_sat;
    logic          w_n_zero;

    assign w_sum      = {1'b0, r_a} + {1'b0, r_b};
    // Once either term has saturated, every later term is also too large
    assign w_step_sat = r_a_ovf | r_b_ovf | w_sum[DW];
    assign w_n_zero   = (r_n == '0);

    // State register
    always_ff @(posedge clk_amisha or posedge reset_amisha) begin
        if (reset_amisha) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; abort outranks completion in OP
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (start_amisha) begin
                    w_state_next = c_S_OP;
                end
            end
            c_S_OP: begin
                if (abort_amisha) begin
                    w_state_next = c_S_IDLE;
                end else if (w_n_zero) begin
                    w_state_next = c_S_DONE;
                end
            end
            c_S_DONE: begin
                w_state_next = c_S_IDLE;
            end
            default: begin
                w_state_next = c_S_IDLE;
            end
        endcase
    end

    // Handshake outputs decoded from the state register only
    always_comb begin
        ready_amisha     = 1'b0;
        done_tick_amisha = 1'b0;
        case (r_state)
            c_S_IDLE: ready_amisha     = 1'b1;
            c_S_DONE: done_tick_amisha = 1'b1;
            default: begin
                ready_amisha     = 1'b0;
                done_tick_amisha = 1'b0;
            end
        endcase
    end

    // Datapath: seed on start, step a/b each OP cycle, capture result at n==0
    always_ff @(posedge clk_amisha or posedge reset_amisha) begin
        if (reset_amisha) begin
            r_a     <= '0;
            r_b     <= '0;
            r_a_ovf <= 1'b0;
            r_b_ovf <= 1'b0;
            r_n     <= '0;
            r_f     <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (start_amisha) begin
                        r_n     <= i_amisha;
                        r_a_ovf <= 1'b0;
                        r_b_ovf <= 1'b0;
                        r_a     <= mode_amisha ? c_SEED_A_LUCAS : c_SEED_A_FIB;
                        r_b     <= c_SEED_B;
                    end
                end
                c_S_OP: begin
                    if (!abort_amisha) begin
                        if (w_n_zero) begin
                            // Overflow is reported from a, so S(i+1) overflowing
                            // does not taint a result S(i) that fits
                            r_f   <= r_a;
                            r_ovf <= r_a_ovf;
                        end else begin
                            r_a     <= r_b;
                            r_a_ovf <= r_b_ovf;
                            r_n     <= r_n - 1'b1;
                            if (w_step_sat) begin
                                r_b     <= c_ALL_ONES;
                                r_b_ovf <= 1'b1;
                            end else begin
                                r_b     <= w_sum[DW-1:0];
                            end
                        end
                    end
                end
                default: begin
                    // DONE: hold everything for the single pulse cycle
                end
            endcase
        end
    end

    assign f_amisha   = r_f;
    assign ovf_amisha = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_fib_param_amisha.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fib_param_amisha
//  Description : Self-checking bench for fib_param_amisha: directed vector
//                table, timing/abort/reset sequences, and random requests
//                compared against an arithmetic sequence model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fib_param_amisha;

    localparam int IW = 5;
    localparam int DW = 20;

    logic          clk;
    logic          rst;
    logic          start;
    logic          mode;
    logic          abort;
    logic [IW-1:0] idx_in;
    logic          ready;
    logic          done_tick;
    logic          ovf;
    logic [DW-1:0] f;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic          m;
        logic [IW-1:0] idx;
        logic [DW-1:0] exp_f;
        logic          exp_ovf;
    } vec_t;

    vec_t vecs[9];

    fib_param_amisha #(.IW(IW), .DW(DW)) dut (
        .clk_amisha       (clk),
        .reset_amisha     (rst),
        .start_amisha     (start),
        .mode_amisha      (mode),
        .abort_amisha     (abort),
        .i_amisha         (idx_in),
        .ready_amisha     (ready),
        .done_tick_amisha (done_tick),
        .ovf_amisha       (ovf),
        .f_amisha         (f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Sequence value by plain iteration, then clipped to the result width
    function automatic void ref_model(input bit m, input int k,
                                      output logic [DW-1:0] rf, output logic ro);
        longint unsigned s0, s1, t;
        s0 = m ? 64'd2 : 64'd0;
        s1 = 64'd1;
        for (int j = 0; j < k; j++) begin
            t  = s0 + s1;
            s0 = s1;
            s1 = t;
        end
        if (s0 >= (64'd1 << DW)) begin
            rf = '1;
            ro = 1'b1;
        end else begin
            rf = s0[DW-1:0];
            ro = 1'b0;
        end
    endfunction

    // One request: checks latency to done_tick, pulse width, result, ready return.
    // Scrambles i/mode right after the start edge to show they are not re-sampled.
    task automatic run_op(input logic m, input logic [IW-1:0] k,
                          input logic [DW-1:0] ef, input logic eo, input string tag);
        int  cyc;
        bit  seen;
        @(negedge clk);
        mode   = m;
        idx_in = k;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        mode   = ~m;
        idx_in = ~k;
        check({tag, "_ready_low"}, 64'(ready), 64'd0);
        cyc  = 0;
        seen = 0;
        while (!seen && cyc < int'(k) + 8) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done_tick) seen = 1;
        end
        check({tag, "_done_latency"}, 64'(cyc), 64'(int'(k) + 1));
        check({tag, "_f"}, 64'(f), 64'(ef));
        check({tag, "_ovf"}, 64'(ovf), 64'(eo));
        @(posedge clk);
        #1;
        check({tag, "_done_width"}, 64'(done_tick), 64'd0);
        check({tag, "_ready_back"}, 64'(ready), 64'd1);
    endtask

    initial begin
        logic [DW-1:0] mf;
        logic          mo;
        bit            saw;
        bit            not_idle;
        int            cyc;
        bit            seen;
        logic          rm;
        logic [IW-1:0] rk;

        vecs[0] = '{1'b0, 5'd8,  20'd21,     1'b0};
        vecs[1] = '{1'b0, 5'd0,  20'd0,      1'b0};
        vecs[2] = '{1'b1, 5'd0,  20'd2,      1'b0};
        vecs[3] = '{1'b1, 5'd1,  20'd1,      1'b0};
        vecs[4] = '{1'b1, 5'd10, 20'd123,    1'b0};
        vecs[5] = '{1'b0, 5'd30, 20'd832040, 1'b0};
        vecs[6] = '{1'b0, 5'd31, 20'hFFFFF,  1'b1};
        vecs[7] = '{1'b1, 5'd29, 20'hFFFFF,  1'b1};
        vecs[8] = '{1'b1, 5'd28, 20'd710647, 1'b0};

        rst    = 1'b0;
        start  = 1'b0;
        mode   = 1'b0;
        abort  = 1'b0;
        idx_in = '0;

        // Asynchronous reset between clock edges
        #2;
        rst = 1'b1;
        #1;
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_done",  64'(done_tick), 64'd0);
        check("rst_f",     64'(f), 64'd0);
        check("rst_ovf",   64'(ovf), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors
        for (int v = 0; v < 9; v++) begin
            run_op(vecs[v].m, vecs[v].idx, vecs[v].exp_f, vecs[v].exp_ovf,
                   $sformatf("vec%0d", v));
        end

        // Abort with an ignored start during OP
        run_op(1'b0, 5'd8, 20'd21, 1'b0, "pre_abort");
        saw = 0;
        @(negedge clk);
        mode   = 1'b0;
        idx_in = 5'd20;
        start  = 1'b1;
        @(posedge clk);          // E0 -> OP cycle 1
        #1;
        start = 1'b0;
        @(negedge clk);
        idx_in = 5'd3;
        start  = 1'b1;
        @(posedge clk);          // E1 -> OP cycle 2
        #1;
        start = 1'b0;
        saw |= done_tick;
        @(posedge clk);          // E2 -> OP cycle 3
        #1;
        saw |= done_tick;
        @(posedge clk);          // E3 -> OP cycle 4
        #1;
        saw |= done_tick;
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);          // E4 samples abort
        #1;
        abort = 1'b0;
        check("abort_ready", 64'(ready), 64'd1);
        check("abort_done",  64'(done_tick), 64'd0);
        check("abort_f",     64'(f), 64'd21);
        check("abort_ovf",   64'(ovf), 64'd0);
        not_idle = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            saw |= done_tick;
            if (!ready) not_idle = 1;
        end
        check("abort_no_done_tick", 64'(saw), 64'd0);
        check("abort_start_not_queued", 64'(not_idle), 64'd0);

        // Abort on the completion edge (n==0) wins over completion
        @(negedge clk);
        mode   = 1'b1;
        idx_in = 5'd2;
        start  = 1'b1;
        @(posedge clk);          // E0
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);   // E1, E2
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);          // E3 = E(i+1)
        #1;
        abort = 1'b0;
        check("abort_last_done", 64'(done_tick), 64'd0);
        check("abort_last_f",    64'(f), 64'd21);
        check("abort_last_ready", 64'(ready), 64'd1);

        // Back-to-back: start held high, request period i+3
        @(negedge clk);
        mode   = 1'b0;
        idx_in = 5'd1;
        start  = 1'b1;
        cyc = 0;
        seen = 0;
        while (!seen && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done_tick) seen = 1;
        end
        check("b2b_first_done", 64'(seen), 64'd1);
        cyc = 0;
        seen = 0;
        while (!seen && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done_tick) seen = 1;
        end
        check("b2b_period", 64'(cyc), 64'd4);
        check("b2b_f", 64'(f), 64'd1);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("b2b_idle", 64'(ready), 64'd1);

        // Asynchronous reset during a long computation
        @(negedge clk);
        mode   = 1'b0;
        idx_in = 5'd25;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_ready", 64'(ready), 64'd1);
        check("mid_rst_done",  64'(done_tick), 64'd0);
        check("mid_rst_f",     64'(f), 64'd0);
        check("mid_rst_ovf",   64'(ovf), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        saw = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            saw |= done_tick;
        end
        check("mid_rst_no_done", 64'(saw), 64'd0);
        run_op(1'b0, 5'd5, 20'd5, 1'b0, "post_rst");

        // Random requests against the arithmetic model
        for (int r = 0; r < 24; r++) begin
            rm = 1'($urandom_range(0, 1));
            rk = IW'($urandom_range(0, (1 << IW) - 1));
            ref_model(rm, int'(rk), mf, mo);
            run_op(rm, rk, mf, mo, $sformatf("rand%0d_m%0d_i%0d", r, rm, rk));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        n_errors++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
